mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 16-bit words; word-addressed.
REQ-002 SHALL have parameter WAIT, default 2: wait cycles inserted before the response, range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port req  input  1  access request; held by the initiator until ready.
REQ-006 SHALL have port addr  input  16  word address.
REQ-007 SHALL have port wdata  input  16  write data.
REQ-008 SHALL have port we  input  2  byte-lane write enables; bit0 = [7:0], bit1 = [15:8].
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port rdata  output  16  read data; valid only while ready is high.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  out-of-range flag; valid only while ready is high.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: on req=1 with (rd=1 or we!=0), SHALL latch addr, wdata, we and rd.
  - WAIT=0: go to RESP.
  - Otherwise: go to WAIT with the counter loaded to WAIT-1.
REQ-015 IDLE: req=1 with rd=0 and we=0 SHALL be ignored; stay in IDLE.
REQ-016 WAIT: SHALL decrement the counter each cycle; go to RESP on the cycle the counter is 0.
REQ-017 RESP: SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-018 Latency: ready SHALL be high in the cycle that starts WAIT+1 edges after the sampling edge.
REQ-019 While in WAIT or RESP, changes on req, addr, wdata, we and rd SHALL be ignored; only latched values are used.
REQ-020 Back-to-back: if req is still high in IDLE after RESP, it SHALL be sampled as a new transaction; there are no idle bubbles beyond the IDLE cycle.
REQ-021 Write: SHALL update only the enabled byte lanes of word latched addr, on the edge that ends RESP.
REQ-022 Read: rdata SHALL equal the word contents before any write of the same transaction (read-before-write when rd and we are both set).
REQ-023 Out of range (addr >= DEPTH):
  - err=1 with ready.
  - rdata=16'h0000.
  - no write.
  - The handshake is otherwise identical.
REQ-024 Outside RESP, ready=0, err=0 and rdata=16'h0000.
REQ-025 we=2'b00 with rd=1 SHALL be a pure read.
REQ-026 we!=0 with rd=0 SHALL be a pure write; rdata SHALL stay 0 during its RESP.

Reset
REQ-027 Asserting reset SHALL immediately force all of the following, independent of clk:
  - state=IDLE
  - ready=0, err=0, rdata=0
  - counter and latched request registers = 0
REQ-028 Reset mid-transaction SHALL abort it; a pending write SHALL NOT occur.
REQ-029 The storage array SHALL NOT be cleared by reset.
REQ-030 The first request after reset deassertion SHALL be sampled on the first rising edge with reset low.

Structure
REQ-031 Shared package mem_pkg SHALL hold:
  - DATA_W=16 and ADDR_W=16
  - the FSM state enum (IDLE/WAIT/RESP)
  - the byte-lane width constant
REQ-032 Storage SHALL be a sub-module mem_array: synchronous byte-lane write, combinational read, no reset.
REQ-033 The FSM, counter, latches and range check SHALL reside in mem_responder.

Verification
REQ-034 WAIT=2: reset, write addr=5 wdata=16'hA55A we=11 -> ready high 3 cycles after sampling, err=0. Then read addr=5 -> rdata=16'hA55A.
REQ-035 Byte lanes: write 16'h1234 to addr 7, then we=01 wdata=16'hFFCD -> read addr 7 = 16'h12CD; then we=10 wdata=16'hEEFF -> read addr 7 = 16'hEECD.
REQ-036 Read+write: addr 9 holds 16'h0001; rd=1 we=11 wdata=16'h0002 -> rdata=16'h0001; a following read returns 16'h0002.
REQ-037 Out of range, DEPTH=256: addr=16'h0100 write 16'hBEEF -> ready and err=1, rdata=0. A read of addr 0 shows no change.
REQ-038 Reset mid-operation: assert reset during WAIT of a write to addr 3 -> ready stays 0 and addr 3 is unchanged; the next read of addr 3 completes normally.
REQ-039 WAIT=0 back-to-back: req held high for 3 reads of addr 1, 2, 3 -> three ready pulses, each one cycle wide, separated by one IDLE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, FSM state encoding and range helper for mem_responder.
// Rev 1.0
`default_nettype none

package mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// mem_array: word storage with per-byte-lane synchronous write and combinational read.
// Rev 1.0
`default_nettype none

module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  we,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents survive reset; only the enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) begin
        mem_q[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: req/ready memory slave with a fixed wait-state count and range check.
// Rev 1.0
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  we,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  we_q;
  logic              rd_q;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sel;
  logic              oor_d;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] mem_rdata;
  logic [LANES-1:0]  wr_lanes;
  logic              start;

  assign start = req && (rd || (we != '0));

  // The response is captured on the edge entering RESP; with WAIT=0 that edge is
  // the sampling edge itself, so the live request is looked up instead of the latch.
  always_comb begin
    rd_addr = addr_q;
    rd_sel  = rd_q;
    if (state_q == ST_IDLE) begin
      rd_addr = addr;
      rd_sel  = rd;
    end
    oor_d   = !in_range(rd_addr, DEPTH);
    rdata_d = (rd_sel && !oor_d) ? mem_rdata : '0;
  end

  // Writing on the edge that ends RESP keeps the returned data read-before-write.
  assign wr_lanes = (state_q == ST_RESP && !err_q) ? we_q : '0;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .we    (wr_lanes),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            rd_q    <= rd;
            if (WAIT == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= oor_d;
              rdata_q <= rdata_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= oor_d;
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, corner sequences and random traffic vs a word-array model.
// Rev 1.0
`default_nettype none

module tb_mem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  we;
    logic        rd;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v   [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic [1:0]  we_v    [2];
  logic        rd_v    [2];
  logic [15:0] rdata_v [2];
  logic        ready_v [2];
  logic        err_v   [2];

  logic [15:0] mdl [2][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .WAIT(2)) dut_w2 (
    .clk(clk), .reset(reset), .req(req_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .we(we_v[0]), .rd(rd_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0])
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset), .req(req_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .we(we_v[1]), .rd(rd_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: word array, out-of-range goes nowhere, read sees old word.
  task automatic model_txn(input int d, input logic [15:0] a, input logic [15:0] wd,
                           input logic [1:0] w, input logic r,
                           output logic [15:0] exp_rd, output logic exp_err);
    int idx;
    idx     = int'(a);
    exp_err = (idx >= DEPTH);
    exp_rd  = 16'h0000;
    if (!exp_err) begin
      if (r) exp_rd = mdl[d][idx];
      if (w[0]) mdl[d][idx] = (mdl[d][idx] & 16'hFF00) | (wd & 16'h00FF);
      if (w[1]) mdl[d][idx] = (mdl[d][idx] & 16'h00FF) | (wd & 16'hFF00);
    end
  endtask

  task automatic scramble_inputs(input int d);
    addr_v[d]  = 16'($urandom);
    wdata_v[d] = 16'($urandom);
    we_v[d]    = 2'($urandom);
    rd_v[d]    = 1'($urandom);
  endtask

  task automatic txn(input int d, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] w, input logic r, input bit scr,
                     output logic [15:0] got_rd, output logic got_err, output int lat);
    logic bad;
    bad        = 1'b0;
    req_v[d]   = 1'b1;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    we_v[d]    = w;
    rd_v[d]    = r;
    lat        = -1;
    got_rd     = 16'h0;
    got_err    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready_v[d] === 1'b1) begin
        lat     = k;
        got_rd  = rdata_v[d];
        got_err = err_v[d];
        break;
      end
      if (rdata_v[d] !== 16'h0 || err_v[d] !== 1'b0) bad = 1'b1;
      if (scr) scramble_inputs(d);
    end
    req_v[d] = 1'b0;
    if (scr) scramble_inputs(d);
    @(posedge clk); #1;
    check("pulse_end", {15'h0, ready_v[d], err_v[d], rdata_v[d]}, 32'h0);
    check("idle_out", {31'h0, bad}, 32'h0);
  endtask

  task automatic check_txn(input int d, input logic [15:0] a, input logic [15:0] wd,
                           input logic [1:0] w, input logic r,
                           input logic [15:0] exp_rd, input logic exp_err,
                           input string tag, input bit scr);
    logic [15:0] got_rd;
    logic        got_err;
    int          lat;
    txn(d, a, wd, w, r, scr, got_rd, got_err, lat);
    check({tag, " latency"}, 32'(lat), (d == 0) ? 32'd3 : 32'd1);
    check({tag, " rdata"}, {16'h0, got_rd}, {16'h0, exp_rd});
    check({tag, " err"}, {31'h0, got_err}, {31'h0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vec[$];
    logic [15:0] e_rd;
    logic        e_err;
    logic [15:0] a, wd;
    logic [1:0]  w;
    logic        r;
    logic        seen;
    logic [5:0]  pattern;
    logic [15:0] b2b_rd [3];
    int          idx;

    vec.push_back('{16'h0005, 16'hA55A, 2'b11, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0005, 16'h0000, 2'b00, 1'b1, 16'hA55A, 1'b0});
    vec.push_back('{16'h0007, 16'h1234, 2'b11, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0007, 16'hFFCD, 2'b01, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0007, 16'h0000, 2'b00, 1'b1, 16'h12CD, 1'b0});
    vec.push_back('{16'h0007, 16'hEEFF, 2'b10, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0007, 16'h0000, 2'b00, 1'b1, 16'hEECD, 1'b0});
    vec.push_back('{16'h0009, 16'h0001, 2'b11, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0009, 16'h0002, 2'b11, 1'b1, 16'h0001, 1'b0});
    vec.push_back('{16'h0009, 16'h0000, 2'b00, 1'b1, 16'h0002, 1'b0});
    vec.push_back('{16'h0000, 16'h0C0C, 2'b11, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0003, 16'h3333, 2'b11, 1'b0, 16'h0000, 1'b0});
    vec.push_back('{16'h0100, 16'hBEEF, 2'b11, 1'b0, 16'h0000, 1'b1});
    vec.push_back('{16'h0100, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1});
    vec.push_back('{16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0C0C, 1'b0});
    vec.push_back('{16'hFFFF, 16'h1234, 2'b11, 1'b1, 16'h0000, 1'b1});

    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0; we_v[d] = '0; rd_v[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 16'h0;
    end

    // Reset takes effect without any clock edge.
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check("reset_outputs", {15'h0, ready_v[d], err_v[d], rdata_v[d]}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // A request with neither rd nor we is not a transaction.
    req_v[0] = 1'b1; we_v[0] = 2'b00; rd_v[0] = 1'b0; addr_v[0] = 16'h0005;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | ready_v[0];
    end
    req_v[0] = 1'b0;
    check("ignored_req", {31'h0, seen}, 32'h0);
    @(posedge clk); #1;

    foreach (vec[i]) begin
      model_txn(0, vec[i].addr, vec[i].wdata, vec[i].we, vec[i].rd, e_rd, e_err);
      check_txn(0, vec[i].addr, vec[i].wdata, vec[i].we, vec[i].rd,
                vec[i].exp_rd, vec[i].exp_err, $sformatf("vec%0d", i), 1'b0);
    end

    // Reset during WAIT of a write aborts it; the first post-reset request is served.
    req_v[0] = 1'b1; addr_v[0] = 16'h0003; wdata_v[0] = 16'hDEAD; we_v[0] = 2'b11; rd_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_outputs", {15'h0, ready_v[0], err_v[0], rdata_v[0]}, 32'h0);
    req_v[0] = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | ready_v[0];
    end
    check("abort_no_ready", {31'h0, seen}, 32'h0);
    @(negedge clk) reset = 1'b0;
    check_txn(0, 16'h0003, 16'h0000, 2'b00, 1'b1, 16'h3333, 1'b0, "after_abort", 1'b0);

    // Reset while ready is high clears the outputs asynchronously.
    req_v[0] = 1'b1; addr_v[0] = 16'h0005; we_v[0] = 2'b00; rd_v[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      seen = ready_v[0];
    end
    check("resp_reached", {31'h0, seen}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_clear", {15'h0, ready_v[0], err_v[0], rdata_v[0]}, 32'h0);
    req_v[0] = 1'b0;
    @(negedge clk) reset = 1'b0;
    check_txn(0, 16'h0005, 16'h0000, 2'b00, 1'b1, 16'hA55A, 1'b0, "mem_kept", 1'b0);

    // Back-to-back reads with WAIT=0 and req held high.
    for (int i = 1; i <= 3; i++) begin
      model_txn(1, 16'(i), 16'(i * 16'h1111), 2'b11, 1'b0, e_rd, e_err);
      check_txn(1, 16'(i), 16'(i * 16'h1111), 2'b11, 1'b0, 16'h0, 1'b0, "b2b_init", 1'b0);
    end
    req_v[1] = 1'b1; addr_v[1] = 16'h0001; we_v[1] = 2'b00; rd_v[1] = 1'b1;
    pattern = '0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pattern[k] = ready_v[1];
      if (ready_v[1] === 1'b1 && idx < 3) begin
        b2b_rd[idx] = rdata_v[1];
        idx++;
        addr_v[1] = 16'(idx + 1);
        if (idx == 3) req_v[1] = 1'b0;
      end
    end
    req_v[1] = 1'b0;
    check("b2b_pattern", {26'h0, pattern}, 32'b010101);
    check("b2b_count", 32'(idx), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_rdata%0d", i), {16'h0, b2b_rd[i]}, 32'((i + 1) * 16'h1111));

    // Random traffic against the model, inputs disturbed while the access is in flight.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = 16'($urandom);
        model_txn(d, 16'(i), wd, 2'b11, 1'b0, e_rd, e_err);
        check_txn(d, 16'(i), wd, 2'b11, 1'b0, e_rd, e_err, "rnd_init", 1'b0);
      end
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(DEPTH, 65535));
        else                           a = 16'($urandom_range(0, 15));
        wd = 16'($urandom);
        w  = 2'($urandom);
        r  = 1'($urandom);
        if (w == 2'b00) r = 1'b1;
        model_txn(d, a, wd, w, r, e_rd, e_err);
        check_txn(d, a, wd, w, r, e_rd, e_err, $sformatf("rnd_d%0d_n%0d", d, n), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
